// File: rtl/fp_to_bcd.sv
// Converts an IEEE-754 single-precision operand to an unsigned 32-bit integer
// and its 10-digit packed BCD form using a serial shifter and double-dabble.
module fp_to_bcd #(
    parameter int ROUND_EN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] fp_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] int_out,
    output logic [39:0] bcd_out,
    output logic        ovf,
    output logic        neg,
    output logic        nan
);

    typedef enum logic [2:0] {IDLE, UNPACK, SHIFT, DABBLE, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] int_out_q, int_out_d;
    logic [39:0] bcd_out_q, bcd_out_d;
    logic        ovf_q, ovf_d;
    logic        neg_q, neg_d;
    logic        nan_q, nan_d;

    logic [31:0] fp_q, fp_d;
    logic [31:0] w_q, w_d;
    logic        r_q, r_d;
    logic        left_q, left_d;
    logic [39:0] bcd_q, bcd_d;
    logic [31:0] sh_q, sh_d;
    logic        ovf_w_q, ovf_w_d;
    logic        neg_w_q, neg_w_d;
    logic        nan_w_q, nan_w_d;

    logic        sgn;
    logic [7:0]  expo;
    logic [22:0] man;

    logic [31:0] cls_w;
    logic [5:0]  cls_k;
    logic        cls_left;
    logic        cls_ovf;
    logic        cls_neg;
    logic        cls_nan;

    logic [31:0] w_shift;
    logic        r_shift;
    logic [32:0] w_rnd;
    logic [39:0] bcd_adj;

    // Adds the round bit when rounding is enabled; a carry out saturates.
    function automatic logic [32:0] round_sat(input logic [31:0] v, input logic r);
        logic [32:0] sum;
        sum = {1'b0, v} + ((ROUND_EN != 0) ? {32'd0, r} : 33'd0);
        return sum[32] ? {1'b1, 32'hFFFF_FFFF} : sum;
    endfunction

    function automatic logic [39:0] dabble_adjust(input logic [39:0] b);
        logic [39:0] a;
        a = b;
        for (int i = 0; i < 10; i++) begin
            if (b[4*i +: 4] >= 4'd5) a[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return a;
    endfunction

    assign sgn  = fp_q[31];
    assign expo = fp_q[30:23];
    assign man  = fp_q[22:0];

    assign busy    = busy_q;
    assign done    = done_q;
    assign int_out = int_out_q;
    assign bcd_out = bcd_out_q;
    assign ovf     = ovf_q;
    assign neg     = neg_q;
    assign nan     = nan_q;

    // Operand classification; special cases load the final result with k=0.
    always_comb begin
        cls_w    = 32'd0;
        cls_k    = 6'd0;
        cls_left = 1'b0;
        cls_ovf  = 1'b0;
        cls_neg  = 1'b0;
        cls_nan  = 1'b0;
        if (expo == 8'hFF && man != 23'd0) begin
            cls_nan = 1'b1;
        end else if (expo == 8'hFF && !sgn) begin
            cls_ovf = 1'b1;
            cls_w   = 32'hFFFF_FFFF;
        end else if (sgn && fp_q[30:0] != 31'd0) begin
            cls_neg = 1'b1;
        end else if (expo >= 8'd159) begin
            cls_ovf = 1'b1;
            cls_w   = 32'hFFFF_FFFF;
        end else if (expo >= 8'd126) begin
            cls_w = {8'd0, 1'b1, man};
            if (expo >= 8'd150) begin
                cls_left = 1'b1;
                cls_k    = 6'(expo - 8'd150);
            end else begin
                cls_k = 6'(8'd150 - expo);
            end
        end
    end

    assign w_shift = left_q ? {w_q[30:0], 1'b0} : {1'b0, w_q[31:1]};
    assign r_shift = left_q ? r_q : w_q[0];
    assign w_rnd   = round_sat(w_shift, r_shift);
    assign bcd_adj = dabble_adjust(bcd_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        int_out_d = int_out_q;
        bcd_out_d = bcd_out_q;
        ovf_d     = ovf_q;
        neg_d     = neg_q;
        nan_d     = nan_q;
        fp_d      = fp_q;
        w_d       = w_q;
        r_d       = r_q;
        left_d    = left_q;
        bcd_d     = bcd_q;
        sh_d      = sh_q;
        ovf_w_d   = ovf_w_q;
        neg_w_d   = neg_w_q;
        nan_w_d   = nan_w_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    fp_d    = fp_in;
                    busy_d  = 1'b1;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                w_d     = cls_w;
                r_d     = 1'b0;
                left_d  = cls_left;
                ovf_w_d = cls_ovf;
                neg_w_d = cls_neg;
                nan_w_d = cls_nan;
                if (cls_k != 6'd0) begin
                    cnt_d   = cls_k;
                    state_d = SHIFT;
                end else begin
                    sh_d    = cls_w;
                    bcd_d   = 40'd0;
                    cnt_d   = 6'd32;
                    state_d = DABBLE;
                end
            end
            SHIFT: begin
                if (cnt_q == 6'd1) begin
                    w_d     = w_rnd[31:0];
                    ovf_w_d = ovf_w_q | w_rnd[32];
                    sh_d    = w_rnd[31:0];
                    bcd_d   = 40'd0;
                    cnt_d   = 6'd32;
                    state_d = DABBLE;
                end else begin
                    w_d   = w_shift;
                    r_d   = r_shift;
                    cnt_d = cnt_q - 6'd1;
                end
            end
            DABBLE: begin
                // sh_q is a scratch copy so the integer result stays intact.
                {bcd_d, sh_d} = {bcd_adj, sh_q} << 1;
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    int_out_d = w_q;
                    bcd_out_d = bcd_d;
                    ovf_d     = ovf_w_q;
                    neg_d     = neg_w_q;
                    nan_d     = nan_w_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 6'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            int_out_q <= 32'd0;
            bcd_out_q <= 40'd0;
            ovf_q     <= 1'b0;
            neg_q     <= 1'b0;
            nan_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            int_out_q <= int_out_d;
            bcd_out_q <= bcd_out_d;
            ovf_q     <= ovf_d;
            neg_q     <= neg_d;
            nan_q     <= nan_d;
        end
    end

    // Working datapath is always written before it is read, so no reset.
    always_ff @(posedge clk) begin
        fp_q    <= fp_d;
        w_q     <= w_d;
        r_q     <= r_d;
        left_q  <= left_d;
        bcd_q   <= bcd_d;
        sh_q    <= sh_d;
        ovf_w_q <= ovf_w_d;
        neg_w_q <= neg_w_d;
        nan_w_q <= nan_w_d;
    end

endmodule
